mic_pcm_conditioner: RTL and testbench
======================================

Name: mic_pcm_conditioner

Overview:
- Sits directly downstream of the PDM microphone / CIC decimator.
- Consumes the 32-bit decimated stream (data + single-cycle valid) and removes DC with a leaky-integrator high-pass.
- Scales and saturates to signed 16-bit PCM, then buffers samples in a small FIFO with a valid/ready output for the audio sink (I2S/PWM player or capture logic).
- Flags saturation and overflow.

Parameters:
- IN_WIDTH, 32, width of signed input samples.
- OUT_WIDTH, 16, width of signed PCM output.
- SHIFT, 8, arithmetic right shift applied after DC removal (0..IN_WIDTH-1).
- DC_K, 10, DC tracker time constant. Estimator leak is 2^-DC_K per sample.
- FIFO_DEPTH, 16, output FIFO entries. Must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- mic_data  in  IN_WIDTH  signed sample from decimator
- mic_data_valid  in  1  one-cycle strobe; mic_data is sampled when it is 1
- bypass_dc  in  1  1 = skip DC removal; the DC estimator holds its value
- clear_ovf  in  1  synchronous clear of the overflow flag
- out_data  out  OUT_WIDTH  signed PCM at FIFO head
- out_valid  out  1  FIFO not empty
- out_ready  in  1  sink accepts out_data when out_valid & out_ready
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO fill count
- sat_pulse  out  1  one-cycle pulse when a sample is clipped
- overflow  out  1  sticky flag: a sample was dropped because the FIFO was full

Behaviour:
- Reset (rst_n=0, asynchronous): all pipeline valids, dc_acc, FIFO pointers, level, sat_pulse and overflow go to 0. out_valid=0 and out_data=0. Release is synchronous to clk.
- Stage A, registered on the edge where mic_data_valid=1:
  - dc_acc is signed, IN_WIDTH+DC_K+1 bits. dc_est = dc_acc >>> DC_K.
  - diff = sext(mic_data) - dc_est, IN_WIDTH+1 bits, exact.
  - If bypass_dc=0: diff_q <= diff and dc_acc <= dc_acc + sext(diff).
  - If bypass_dc=1: diff_q <= sext(mic_data) and dc_acc is held.
  - a_valid <= mic_data_valid.
- Stage B, on a_valid:
  - s = diff_q >>> SHIFT (arithmetic, truncation toward -inf).
  - If s > 2^(OUT_WIDTH-1)-1, b_data = max positive. If s < -2^(OUT_WIDTH-1), b_data = min negative. Otherwise b_data = s[OUT_WIDTH-1:0].
  - sat_pulse = 1 for exactly the cycle b_valid is 1 on a clipped sample.
- FIFO write:
  - On b_valid, write if level < FIFO_DEPTH, or if level == FIFO_DEPTH and a pop occurs in the same cycle (push+pop at full is accepted).
  - Otherwise drop the sample and set overflow. Existing contents are untouched.
- Latency: a sample strobed at edge N is written at edge N+2. With the FIFO empty, out_valid=1 and out_data holds the sample after edge N+2. The FIFO is first-word-fall-through with a combinational read of the head entry.
- Pop: on the edge where out_valid & out_ready. out_ready with an empty FIFO is ignored.
- level:
  - +1 on push only, -1 on pop only, unchanged on push+pop.
  - Never exceeds FIFO_DEPTH and never underflows.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow:
  - Set on a drop and held until clear_ovf=1.
  - If a drop and clear_ovf occur in the same cycle, set wins.
- Back-to-back strobes on every cycle are supported at full throughput; the pipeline has no stall. The upstream has no ready, so the FIFO is the only elasticity.
- Toggling bypass_dc mid-stream takes effect for the next strobed sample. dc_acc resumes from its held value.
- Reset asserted mid-stream flushes the pipeline and FIFO. In-flight samples are lost and no partial output appears.

Test Plan:
- bypass_dc=1, single strobe mic_data=0x00012345, out_ready=1 -> 2 cycles later out_valid=1, out_data=0x0123, sat_pulse=0, level returns to 0 after pop.
- bypass_dc=1, strobes 0x7FFFFFFF then 0x80000000 -> outputs 0x7FFF then 0x8000, with one sat_pulse each.
- bypass_dc=0, from reset, constant 0x00100000 on every strobe -> first output 0x1000, then monotonically decaying. After 8192 samples |out_data| <= 2. dc_acc>>>DC_K is within 0x200 of 0x00100000.
- out_ready=0, 20 strobes of values 1..20<<8 (bypass) -> level saturates at 16, overflow=1 from the 17th write. Draining yields 1..16 in order, then out_valid=0. clear_ovf drops overflow.
- FIFO full with out_ready=1, plus a new strobe arriving at the write edge -> write accepted, level stays 16, overflow stays 0, order preserved.
- Reset pulse asserted mid-burst with the FIFO half full -> out_valid, level, overflow and sat_pulse are 0 immediately (asynchronous). The first post-reset sample in bypass appears at the correct latency with no stale data.

Source files
------------

// File: rtl/mic_pcm_conditioner.sv
// mic_pcm_conditioner: leaky-integrator DC removal, scale/saturate to PCM,
// and a first-word-fall-through output FIFO feeding the audio sink.
module mic_pcm_conditioner #(
    parameter int IN_WIDTH   = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int SHIFT      = 8,
    parameter int DC_K       = 10,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [IN_WIDTH-1:0]         mic_data,
    input  logic                        mic_data_valid,
    input  logic                        bypass_dc,
    input  logic                        clear_ovf,
    output logic [OUT_WIDTH-1:0]        out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        sat_pulse,
    output logic                        overflow
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LW    = AW + 1;
    localparam int DW    = IN_WIDTH + 1;
    localparam int ACC_W = IN_WIDTH + DC_K + 1;

    localparam logic signed [DW-1:0] PCM_MAX =
        {{(DW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [DW-1:0] PCM_MIN =
        {{(DW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [OUT_WIDTH-1:0] OUT_MAX =
        {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] OUT_MIN =
        {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic signed [ACC_W-1:0] dc_acc;
    logic signed [DW-1:0]    mic_dw;
    logic signed [DW-1:0]    diff;
    logic signed [DW-1:0]    diff_q;
    logic                    a_valid;

    assign mic_dw = {mic_data[IN_WIDTH-1], mic_data};
    // The tracked DC estimate stays inside the input range, so the
    // difference always fits in one extra bit.
    assign diff = DW'(mic_dw - (dc_acc >>> DC_K));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid <= 1'b0;
            diff_q  <= '0;
            dc_acc  <= '0;
        end else begin
            a_valid <= mic_data_valid;
            if (mic_data_valid) begin
                if (bypass_dc) begin
                    diff_q <= mic_dw;
                end else begin
                    diff_q <= diff;
                    dc_acc <= dc_acc + {{(ACC_W-DW){diff[DW-1]}}, diff};
                end
            end
        end
    end

    logic signed [DW-1:0]  scaled;
    logic [OUT_WIDTH-1:0]  b_next;
    logic                  clip;
    logic [OUT_WIDTH-1:0]  b_data;
    logic                  b_valid;

    assign scaled = diff_q >>> SHIFT;

    always_comb begin
        b_next = scaled[OUT_WIDTH-1:0];
        clip   = 1'b0;
        unique case (1'b1)
            (scaled > PCM_MAX): begin
                b_next = OUT_MAX;
                clip   = 1'b1;
            end
            (scaled < PCM_MIN): begin
                b_next = OUT_MIN;
                clip   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_valid   <= 1'b0;
            b_data    <= '0;
            sat_pulse <= 1'b0;
        end else begin
            b_valid   <= a_valid;
            sat_pulse <= a_valid & clip;
            if (a_valid) begin
                b_data <= b_next;
            end
        end
    end

    logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic                 full;
    logic                 pop;
    logic                 push;
    logic                 drop;

    assign out_valid = (level != '0);
    assign full      = (level == LW'(FIFO_DEPTH));
    assign pop       = out_valid & out_ready;
    // A pop frees the head slot on the same edge, so a full FIFO
    // still accepts a write when the sink is draining.
    assign push      = b_valid & (~full | pop);
    assign drop      = b_valid & ~push;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= b_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mic_pcm_conditioner.sv
// Testbench for mic_pcm_conditioner: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_mic_pcm_conditioner;
    localparam int FD = 16;
    localparam int SH = 8;
    localparam int K  = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] mic_data;
    logic        mic_data_valid;
    logic        bypass_dc;
    logic        clear_ovf;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  level;
    logic        sat_pulse;
    logic        overflow;

    mic_pcm_conditioner dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mic_data       (mic_data),
        .mic_data_valid (mic_data_valid),
        .bypass_dc      (bypass_dc),
        .clear_ovf      (clear_ovf),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .level          (level),
        .sat_pulse      (sat_pulse),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    longint      m_acc;
    bit          a_v;
    longint      a_d;
    bit          b_v;
    logic [15:0] b_d;
    bit          b_s;
    bit          m_ovf;
    logic [15:0] q[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = 0;
        a_v   = 0;
        a_d   = 0;
        b_v   = 0;
        b_d   = '0;
        b_s   = 0;
        m_ovf = 0;
        q.delete();
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_level"}, level, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_sat"}, sat_pulse, 0);
        chk({tag, "_ovf"}, overflow, 0);
    endtask

    // Advance one clock with the inputs currently driven, then compare.
    task automatic cyc();
        bit     pop;
        bit     ok;
        longint x;
        longint s;
        longint d;
        pop = (q.size() > 0) && out_ready;
        ok  = (q.size() < FD) || pop;
        if (b_v && !ok) m_ovf = 1;
        else if (clear_ovf) m_ovf = 0;
        if (pop) void'(q.pop_front());
        if (b_v && ok) q.push_back(b_d);
        b_v = a_v;
        if (a_v) begin
            s = a_d >>> SH;
            b_s = 1;
            if (s > 32767) b_d = 16'h7FFF;
            else if (s < -32768) b_d = 16'h8000;
            else begin
                b_d = 16'(s);
                b_s = 0;
            end
        end
        a_v = mic_data_valid;
        if (mic_data_valid) begin
            x = longint'($signed(mic_data));
            if (bypass_dc) a_d = x;
            else begin
                d = x - (m_acc >>> K);
                a_d = d;
                m_acc += d;
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, q.size() > 0);
        chk("level", level, q.size());
        chk("out_data", out_data, q.size() > 0 ? q[0] : 16'h0);
        chk("sat_pulse", sat_pulse, b_v && b_s);
        chk("overflow", overflow, m_ovf);
    endtask

    task automatic strobe(input logic [31:0] v);
        mic_data       = v;
        mic_data_valid = 1'b1;
        cyc();
        mic_data_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic areset(input string tag);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_idle(tag);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int prev;
        int v;
        rst_n          = 1'b0;
        mic_data       = '0;
        mic_data_valid = 1'b0;
        bypass_dc      = 1'b1;
        clear_ovf      = 1'b0;
        out_ready      = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");
        rst_n = 1'b1;

        // single bypass sample, two-cycle latency
        out_ready = 1'b1;
        strobe(32'h0001_2345);
        chk("lat1_valid", out_valid, 0);
        cyc();
        chk("lat2_valid", out_valid, 0);
        chk("lat2_sat", sat_pulse, 0);
        cyc();
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, 16'h0123);
        cyc();
        chk("single_level", level, 0);

        // clipping in both directions
        strobe(32'h7FFF_FFFF);
        strobe(32'h8000_0000);
        chk("sat_hi_pulse", sat_pulse, 1);
        cyc();
        chk("sat_lo_pulse", sat_pulse, 1);
        chk("sat_hi_data", out_data, 16'h7FFF);
        cyc();
        chk("sat_lo_data", out_data, 16'h8000);
        chk("sat_done", sat_pulse, 0);
        idle(2);

        // DC removal of a constant input
        areset("pre_dc");
        bypass_dc = 1'b0;
        out_ready = 1'b1;
        prev = 32767;
        for (int i = 0; i < 8192; i++) begin
            mic_data       = 32'h0010_0000;
            mic_data_valid = 1'b1;
            cyc();
            if (i == 2) chk("dc_first", out_data, 16'h1000);
            if (i >= 2) begin
                chk("dc_decay", int'($signed(out_data)) <= prev, 1);
                prev = $signed(out_data);
            end
        end
        mic_data_valid = 1'b0;
        v = $signed(out_data);
        chk("dc_settle", (v <= 2) && (v >= -2), 1);
        idle(3);

        // fill past capacity with the sink stalled
        bypass_dc = 1'b1;
        out_ready = 1'b0;
        for (int i = 1; i <= 20; i++) strobe(32'(i << 8));
        idle(2);
        chk("ovf_level", level, 16);
        chk("ovf_flag", overflow, 1);
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            chk("drain_order", out_data, i);
            cyc();
        end
        chk("drain_empty", out_valid, 0);
        clear_ovf = 1'b1;
        cyc();
        clear_ovf = 1'b0;
        chk("ovf_cleared", overflow, 0);

        // write into a full FIFO on the same edge as a pop
        out_ready = 1'b0;
        for (int i = 1; i <= 17; i++) strobe(32'(i << 8));
        idle(1);
        chk("full_level", level, 16);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("pushpop_level", level, 16);
        chk("pushpop_ovf", overflow, 0);
        out_ready = 1'b1;
        for (int i = 2; i <= 17; i++) begin
            chk("pushpop_order", out_data, i);
            cyc();
        end
        chk("pushpop_empty", out_valid, 0);

        // asynchronous reset with the FIFO half full and samples in flight
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) strobe(32'(i << 8));
        idle(2);
        chk("half_level", level, 8);
        mic_data       = 32'h0000_5500;
        mic_data_valid = 1'b1;
        cyc();
        cyc();
        areset("midrst");
        mic_data_valid = 1'b0;
        out_ready      = 1'b1;
        strobe(32'h0012_3400);
        chk("post_lat1", out_valid, 0);
        cyc();
        chk("post_lat2", out_valid, 0);
        cyc();
        chk("post_valid", out_valid, 1);
        chk("post_data", out_data, 16'h1234);
        idle(2);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1) == 0) mic_data = $urandom;
            else mic_data = 32'($urandom_range(0, 1 << 20)) - 32'(1 << 19);
            mic_data_valid = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 31) == 0) bypass_dc = ~bypass_dc;
            out_ready = $urandom_range(0, 2) != 0;
            clear_ovf = $urandom_range(0, 15) == 0;
            cyc();
        end
        mic_data_valid = 1'b0;
        clear_ovf      = 1'b0;
        out_ready      = 1'b1;
        idle(FD + 3);
        chk("final_empty", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
